// File: rtl/dot_product_row_feeder.sv
`default_nettype none
// ============================================================================
// Module      : dot_product_row_feeder
// Description : Producer side of the dot-product row interface. Reads
//               matrix row A and vector B element by element from two
//               single-port memories and packs them into no_of_units-wide
//               packages. Each package is offered with a one-cycle
//               outsider_read_now strobe. The next package is fetched only
//               after the consumer answers with I_am_ready. Once the last
//               package is accepted, the consumer's dot_product_output is
//               captured on a fresh rising edge of finish.
//
// Ports       : clk, reset (async, active-high)
//               start, total, base_addr_a, base_addr_b      - job request
//               mem_addr_a/b, mem_rd, mem_data_a/b          - operand SRAMs
//                                                             (1-cycle latency)
//               first_row_input, second_row_input,
//               outsider_read_now, consumer_total,
//               I_am_ready, finish, dot_product_output      - consumer side
//               result, done, busy, error                   - job status
//
// Option      : ZERO_PAD_EN - when defined, a total that is not a multiple
//               of no_of_units is accepted. The tail of the last package is
//               filled with zeros instead of being read from memory.
//
// Revision    : 1.0 - initial release
// ============================================================================
module dot_product_row_feeder #(
  parameter int element_width = 32,
  parameter int no_of_units   = 8,
  parameter int addr_width    = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [31:0]                            total,
  input  logic [addr_width-1:0]                  base_addr_a,
  input  logic [addr_width-1:0]                  base_addr_b,
  output logic [addr_width-1:0]                  mem_addr_a,
  output logic [addr_width-1:0]                  mem_addr_b,
  output logic                                   mem_rd,
  input  logic [element_width-1:0]               mem_data_a,
  input  logic [element_width-1:0]               mem_data_b,
  output logic [element_width*no_of_units-1:0]   first_row_input,
  output logic [element_width*no_of_units-1:0]   second_row_input,
  output logic                                   outsider_read_now,
  output logic [31:0]                            consumer_total,
  input  logic                                   I_am_ready,
  input  logic                                   finish,
  input  logic [element_width-1:0]               dot_product_output,
  output logic [element_width-1:0]               result,
  output logic                                   done,
  output logic                                   busy,
  output logic                                   error
);

  localparam int LG = $clog2(no_of_units);
  localparam int CW = LG + 1;
  localparam int W  = element_width;
  localparam int PW = element_width * no_of_units;
  // r_k runs from 0 up to no_of_units. The extra step is the cycle that
  // waits for the last read data.
  localparam logic [CW-1:0] K_LAST = CW'(no_of_units);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT_RDY = 3'd3,
    S_WAIT_FIN = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [addr_width-1:0] r_base_a, r_base_b;
  logic [31:0]           r_total, r_pkgs, r_pkg_cnt, r_elem_idx;
  logic [CW-1:0]         r_k;
  logic                  r_fill, r_fill_rd;
  logic [LG-1:0]         r_fill_slot;
  logic [W-1:0]          r_pkg_a [no_of_units];
  logic [W-1:0]          r_pkg_b [no_of_units];
  logic                  r_fin_q, r_fin_seen;

  logic        w_len_bad, w_slot_cycle, w_rd, w_fin_rise, w_fin_ok, w_last_pkg;
  logic [31:0] w_pkgs;

  // ceil(total / no_of_units)
  assign w_pkgs = (total >> LG) + {31'b0, |total[LG-1:0]};

`ifdef ZERO_PAD_EN
  assign w_len_bad = (total == 32'd0);
`else
  assign w_len_bad = (total == 32'd0) || (total[LG-1:0] != '0);
`endif

  // A slot cycle only issues a read while the element exists. Without
  // padding this comparison is always true.
  assign w_slot_cycle = (state == S_FETCH) && (r_k != K_LAST);
  assign w_rd         = w_slot_cycle && (r_elem_idx < r_total);

  assign mem_addr_a = w_rd ? (r_base_a + addr_width'(r_elem_idx)) : '0;
  assign mem_addr_b = w_rd ? (r_base_b + addr_width'(r_elem_idx)) : '0;

  // finish is sticky in the consumer. It is accepted only when a rising
  // edge has been seen after the last ISSUE of this job.
  assign w_fin_rise = finish & ~r_fin_q;
  assign w_fin_ok   = finish & (r_fin_seen | w_fin_rise);
  assign w_last_pkg = (r_pkg_cnt + 32'd1) >= r_pkgs;

  // Element 0 sits in the top slice of each package.
  for (genvar i = 0; i < no_of_units; i++) begin : g_pack
    assign first_row_input [PW-1-i*W -: W] = r_pkg_a[i];
    assign second_row_input[PW-1-i*W -: W] = r_pkg_b[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    busy              = (state != S_IDLE);
    outsider_read_now = (state == S_ISSUE);
    mem_rd            = w_rd;
    case (state)
      S_IDLE:     if (start && !w_len_bad) state_nxt = S_FETCH;
      S_FETCH:    if (r_k == K_LAST) state_nxt = S_ISSUE;
      S_ISSUE:    state_nxt = S_WAIT_RDY;
      S_WAIT_RDY: if (I_am_ready) state_nxt = w_last_pkg ? S_WAIT_FIN : S_FETCH;
      S_WAIT_FIN: if (w_fin_ok) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base_a       <= '0;
      r_base_b       <= '0;
      r_total        <= '0;
      r_pkgs         <= '0;
      r_pkg_cnt      <= '0;
      r_elem_idx     <= '0;
      r_k            <= '0;
      r_fill         <= 1'b0;
      r_fill_rd      <= 1'b0;
      r_fill_slot    <= '0;
      r_fin_q        <= 1'b0;
      r_fin_seen     <= 1'b0;
      consumer_total <= '0;
      result         <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
      for (int i = 0; i < no_of_units; i++) begin
        r_pkg_a[i] <= '0;
        r_pkg_b[i] <= '0;
      end
    end else begin
      done    <= 1'b0;
      r_fin_q <= finish;

      // Read data returns one cycle after the address. Remember which slot
      // it belongs to and whether the slot was really read or is padding.
      r_fill      <= w_slot_cycle;
      r_fill_rd   <= w_rd;
      r_fill_slot <= r_k[LG-1:0];
      if (r_fill) begin
        r_pkg_a[r_fill_slot] <= r_fill_rd ? mem_data_a : '0;
        r_pkg_b[r_fill_slot] <= r_fill_rd ? mem_data_b : '0;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            if (w_len_bad) begin
              error <= 1'b1;
            end else begin
              error          <= 1'b0;
              r_base_a       <= base_addr_a;
              r_base_b       <= base_addr_b;
              r_total        <= total;
              r_pkgs         <= w_pkgs;
              consumer_total <= w_pkgs << LG;
              r_pkg_cnt      <= '0;
              r_elem_idx     <= '0;
              r_k            <= '0;
            end
          end
        end
        S_FETCH: begin
          if (r_k != K_LAST) begin
            r_k        <= r_k + CW'(1);
            r_elem_idx <= r_elem_idx + 32'd1;
          end
        end
        S_ISSUE: r_fin_seen <= 1'b0;
        S_WAIT_RDY: begin
          if (w_fin_rise) r_fin_seen <= 1'b1;
          if (I_am_ready) begin
            r_pkg_cnt <= r_pkg_cnt + 32'd1;
            r_k       <= '0;
          end
        end
        S_WAIT_FIN: begin
          if (w_fin_rise) r_fin_seen <= 1'b1;
          if (w_fin_ok) begin
            result <= dot_product_output;
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
